// File: rtl/spi_reg_responder_pkg.sv
// Shared types and constants for the SPI register responder.
// FSM state encoding, command-byte layout and the address-increment helper live here.
package spi_reg_responder_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Frame addresses wrap modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pad input, with level and one-cycle edge pulses.
// STAGES must be at least 2; RST_VAL is the idle level the chain holds while in reset.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target exposing a byte-wide register bank; SPI pins are oversampled in axi_aclk.
// Optional: define SPI_REG_RESPONDER_ERR_CNT_EN to map a saturating frame-error counter at N_REGS-1.
module spi_reg_responder
  import spi_reg_responder_pkg::*;
#(
  parameter int                N_REGS      = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic                     spi_sck_i,
  input  logic                     spi_csn_i,
  input  logic                     spi_mosi_i,
  output logic                     spi_miso_o,
  output logic                     spi_miso_t,
  output logic [N_REGS*BYTE_W-1:0] regs_o,
  output logic                     wr_stb_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [BYTE_W-1:0]        wr_data_o,
  output logic                     frame_err_o
);

  localparam int IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

  logic sck_rise, sck_fall, sck_level_unused;
  logic csn_level, csn_rise, csn_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(axi_aclk), .rst_n(axi_aresetn), .d_i(spi_sck_i),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(axi_aclk), .rst_n(axi_aresetn), .d_i(spi_csn_i),
    .level_o(csn_level), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(axi_aclk), .rst_n(axi_aresetn), .d_i(spi_mosi_i),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                miso_q, miso_d;
  logic                miso_t_q, miso_t_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_err_q, frame_err_d;
  logic [SETTLE_W-1:0] settle_q;
  logic [BYTE_W-1:0]   regs_q [N_REGS];

  logic                settled;
  logic                frame_active;
  logic                byte_done;
  logic [BYTE_W-1:0]   rx_byte;
  logic [ADDR_W-1:0]   rd_addr;
  logic [BYTE_W-1:0]   rd_data;
  logic                wr_ok;
  logic                wr_en;

`ifdef SPI_REG_RESPONDER_ERR_CNT_EN
  logic              clr_q;
  logic              err_clr;
  logic [BYTE_W-1:0] err_cnt_q;
`endif

  // The csn synchronizer comes out of reset high; if the pad is already low, the
  // resulting falling edge belongs to a frame that began before reset and is ignored.
  assign settled      = (settle_q == SETTLE_W'(SYNC_STAGES + 1));
  assign frame_active = (state_q != IDLE) && !csn_level;
  assign byte_done    = frame_active && sck_rise && (bit_cnt_q == 3'd7);
  assign rx_byte      = {rx_shift_q[BYTE_W-2:0], mosi_s};

  // In CMD the next read byte comes from the address being latched; in DATA from addr+1.
  assign rd_addr = (state_q == CMD) ? rx_byte[ADDR_W-1:0] : addr_inc(addr_q);

  always_comb begin
    rd_data = '0;
    if (rd_addr == '0) begin
      rd_data = ID_VALUE;
    end else if (int'(rd_addr) < N_REGS) begin
      rd_data = regs_q[rd_addr[IDX_W-1:0]];
`ifdef SPI_REG_RESPONDER_ERR_CNT_EN
      if (int'(rd_addr) == N_REGS - 1) rd_data = err_cnt_q;
`endif
    end
  end

  always_comb begin
    wr_ok = (addr_q != '0) && (int'(addr_q) < N_REGS);
`ifdef SPI_REG_RESPONDER_ERR_CNT_EN
    if (int'(addr_q) == N_REGS - 1) wr_ok = 1'b0;
`endif
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    miso_d      = miso_q;
    miso_t_d    = miso_t_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;

    if (csn_rise) begin
      frame_err_d = (state_q != IDLE) && (bit_cnt_q != 3'd0);
      state_d     = IDLE;
      bit_cnt_d   = '0;
      addr_d      = '0;
      rx_shift_d  = '0;
      tx_shift_d  = '0;
      rw_d        = 1'b0;
      miso_d      = 1'b0;
      miso_t_d    = 1'b1;
    end else if (csn_fall && settled) begin
      state_d    = CMD;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      miso_d     = 1'b0;
      miso_t_d   = 1'b0;
    end else if (frame_active && sck_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (byte_done) begin
        if (state_q == CMD) begin
          state_d = DATA;
          rw_d    = rx_byte[CMD_RW_BIT];
          addr_d  = rx_byte[ADDR_W-1:0];
          if (rx_byte[CMD_RW_BIT]) begin
            tx_shift_d = rd_data;
            miso_d     = rd_data[BYTE_W-1];
          end
        end else if (!rw_q) begin
          wr_en    = wr_ok;
          wr_stb_d = wr_ok;
          if (wr_ok) begin
            wr_addr_d = addr_q;
            wr_data_d = rx_byte;
          end
          addr_d = addr_inc(addr_q);
        end else begin
          addr_d     = addr_inc(addr_q);
          tx_shift_d = rd_data;
          miso_d     = rd_data[BYTE_W-1];
        end
      end
    end else if (frame_active && sck_fall && (state_q == DATA) && rw_q && (bit_cnt_q != 3'd0)) begin
      // The fall that closes a byte is skipped so a freshly loaded MSB stays on the
      // line through the first rise of the next byte.
      tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
      miso_d     = tx_shift_q[BYTE_W-2];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      miso_t_q    <= 1'b1;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      miso_q      <= miso_d;
      miso_t_q    <= miso_t_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      if (!settled) settle_q <= settle_q + SETTLE_W'(1);
    end
  end

  // NOTE: the bank is a handful of flops visible to fabric logic, so it is reset like any other state.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[addr_q[IDX_W-1:0]] <= rx_byte;
    end
  end

`ifdef SPI_REG_RESPONDER_ERR_CNT_EN
  // A frame whose command is a write to address 127 clears the counter on its first data byte.
  assign err_clr = byte_done && (state_q == DATA) && !rw_q && clr_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      clr_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (csn_rise) begin
        clr_q <= 1'b0;
      end else if (byte_done && (state_q == CMD)) begin
        clr_q <= (rx_byte == 8'h7F);
      end
      if (err_clr) begin
        err_cnt_q <= '0;
      end else if (frame_err_d && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
`endif

  for (genvar k = 0; k < N_REGS; k++) begin : g_regs_out
    assign regs_o[k*BYTE_W +: BYTE_W] = regs_q[k];
  end

  assign spi_miso_o  = miso_q;
  assign spi_miso_t  = miso_t_q;
  assign wr_stb_o    = wr_stb_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = frame_err_q;

endmodule
